// File: rtl/id_ex_stage_buf_if.sv
// Decode-to-execute link: valid/ready input side carrying the raw instruction,
// valid/ready output side carrying the extracted register fields.
interface id_ex_stage_buf_if #(
  parameter int DATA_W = 192,
  parameter int PC_W   = 32,
  parameter int CTRL_W = 11
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [PC_W-1:0]   in_pc;
  logic [CTRL_W-1:0] in_ctrl;
  logic [31:0]       in_instr;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PC_W-1:0]   out_pc;
  logic [CTRL_W-1:0] out_ctrl;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;

  modport master (
    output in_valid, in_data, in_pc, in_ctrl, in_instr, out_ready,
    input  in_ready, out_valid, out_data, out_pc, out_ctrl, out_rs1, out_rs2, out_rd
  );

  modport slave (
    input  in_valid, in_data, in_pc, in_ctrl, in_instr, out_ready,
    output in_ready, out_valid, out_data, out_pc, out_ctrl, out_rs1, out_rs2, out_rd
  );
endinterface

// File: rtl/id_ex_stage_buf.sv
// ID/EX stage buffer, 1-cycle latency, valid/ready backpressure; flush inserts a bubble.
// ID_EX_SKID_EN builds a 2-entry skid FSM so in_ready is purely registered.
module id_ex_stage_buf #(
  parameter int DATA_W = 192,
  parameter int PC_W   = 32,
  parameter int CTRL_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  id_ex_stage_buf_if.slave bus,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  entry_t           w_in_entry;
  entry_t           w_out_entry;
  entry_t           r_head;
  logic             r_head_vld;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_unused_instr;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Only the register specifiers are kept; the rest of the instruction is dropped.
  assign w_in_entry = {bus.in_data, bus.in_pc, bus.in_ctrl,
                       bus.in_instr[19:15], bus.in_instr[24:20], bus.in_instr[11:7]};
  assign w_unused_instr = ^{bus.in_instr[31:25], bus.in_instr[14:12], bus.in_instr[6:0]};

  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = r_head_vld & bus.out_ready;

`ifdef ID_EX_SKID_EN
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t r_state;
  entry_t r_skid;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_state    <= S_EMPTY;
      r_head_vld <= 1'b0;
      r_head     <= '0;
      r_skid     <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            r_head     <= w_in_entry;
            r_head_vld <= 1'b1;
            r_state    <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_head <= w_in_entry;
          end else if (w_in_fire) begin
            r_skid  <= w_in_entry;
            r_state <= S_TWO;
          end else if (w_out_fire) begin
            r_head     <= '0;
            r_head_vld <= 1'b0;
            r_state    <= S_EMPTY;
          end
        end
        S_TWO: begin
          // in_ready is low here, so only a drain can happen
          if (w_out_fire) begin
            r_head  <= r_skid;
            r_skid  <= '0;
            r_state <= S_ONE;
          end
        end
        default: begin
          r_state    <= S_EMPTY;
          r_head_vld <= 1'b0;
          r_head     <= '0;
          r_skid     <= '0;
        end
      endcase
    end
  end

  assign w_in_ready = !reset && (r_state != S_TWO);
`else
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_head_vld <= 1'b0;
      r_head     <= '0;
    end else if (w_in_fire) begin
      r_head     <= w_in_entry;
      r_head_vld <= 1'b1;
    end else if (w_out_fire) begin
      r_head     <= '0;
      r_head_vld <= 1'b0;
    end
  end

  assign w_in_ready = !reset && (!r_head_vld || bus.out_ready);
`endif

  // Saturating bubble counter; survives flush, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (!r_head_vld && bus.out_ready && (r_bubble_cnt != CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
    end
  end

  // Invalid head presents an all-zero (NOP) bundle downstream.
  assign w_out_entry = r_head_vld ? r_head : '0;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_head_vld;
  assign bus.out_data  = w_out_entry.data;
  assign bus.out_pc    = w_out_entry.pc;
  assign bus.out_ctrl  = w_out_entry.ctrl;
  assign bus.out_rs1   = w_out_entry.rs1;
  assign bus.out_rs2   = w_out_entry.rs2;
  assign bus.out_rd    = w_out_entry.rd;
  assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Bench for id_ex_stage_buf: directed vector table, stall/flush sequences, then
// random traffic against a queue-based model; a CNT_W=2 copy checks saturation.
module tb_id_ex_stage_buf;
  localparam int DW = 192;
  localparam int PW = 32;
  localparam int CW = 11;
`ifdef ID_EX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clock;
  logic        tb_rst;
  logic        tb_flush;
  logic [15:0] cnt16;
  logic [1:0]  cnt2;

  id_ex_stage_buf_if #(.DATA_W(DW), .PC_W(PW), .CTRL_W(CW)) bus ();
  id_ex_stage_buf_if #(.DATA_W(DW), .PC_W(PW), .CTRL_W(CW)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.in_pc     = bus.in_pc;
  assign bus2.in_ctrl   = bus.in_ctrl;
  assign bus2.in_instr  = bus.in_instr;
  assign bus2.out_ready = bus.out_ready;

  id_ex_stage_buf #(.DATA_W(DW), .PC_W(PW), .CTRL_W(CW), .CNT_W(16)) u_dut (
    .clock(clock), .reset(tb_rst), .flush(tb_flush), .bus(bus), .bubble_cnt(cnt16));
  id_ex_stage_buf #(.DATA_W(DW), .PC_W(PW), .CTRL_W(CW), .CNT_W(2)) u_dut2 (
    .clock(clock), .reset(tb_rst), .flush(tb_flush), .bus(bus2), .bubble_cnt(cnt2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: an ordered queue of accepted entries.
  typedef struct packed {
    logic [DW-1:0] data;
    logic [PW-1:0] pc;
    logic [CW-1:0] ctrl;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
  } ent_t;

  ent_t mq[$];
  int   mcnt16 = 0;
  int   mcnt2  = 0;

  function automatic logic model_rdy();
    if (tb_rst) return 1'b0;
`ifdef ID_EX_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || bus.out_ready;
`endif
  endfunction

  task automatic model_update();
    ent_t e;
    logic in_f;
    logic out_f;
    if (tb_rst) begin
      mq.delete();
      mcnt16 = 0;
      mcnt2  = 0;
    end else begin
      if (mq.size() == 0 && bus.out_ready) begin
        if (mcnt16 < 65535) mcnt16++;
        if (mcnt2 < 3) mcnt2++;
      end
      in_f  = bus.in_valid && model_rdy();
      out_f = (mq.size() > 0) && bus.out_ready;
      if (tb_flush) begin
        mq.delete();
      end else begin
        if (out_f) void'(mq.pop_front());
        if (in_f) begin
          e.data = bus.in_data;
          e.pc   = bus.in_pc;
          e.ctrl = bus.in_ctrl;
          e.rs1  = bus.in_instr[19:15];
          e.rs2  = bus.in_instr[24:20];
          e.rd   = bus.in_instr[11:7];
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic check_model();
    ent_t e;
    e = (mq.size() > 0) ? mq[0] : '0;
    chk("in_ready",   192'(bus.in_ready),  192'(model_rdy()));
    chk("out_valid",  192'(bus.out_valid), 192'(mq.size() > 0));
    chk("out_data",   192'(bus.out_data),  192'(e.data));
    chk("out_pc",     192'(bus.out_pc),    192'(e.pc));
    chk("out_ctrl",   192'(bus.out_ctrl),  192'(e.ctrl));
    chk("out_rs1",    192'(bus.out_rs1),   192'(e.rs1));
    chk("out_rs2",    192'(bus.out_rs2),   192'(e.rs2));
    chk("out_rd",     192'(bus.out_rd),    192'(e.rd));
    chk("bubble_cnt", 192'(cnt16),         192'(mcnt16));
    chk("w2_bubble_cnt", 192'(cnt2),       192'(mcnt2));
    chk("w2_in_ready",   192'(bus2.in_ready),  192'(model_rdy()));
    chk("w2_out_valid",  192'(bus2.out_valid), 192'(mq.size() > 0));
    chk("w2_out_entry",
        192'({bus2.out_data ^ {6{bus2.out_pc}}, bus2.out_ctrl, bus2.out_rs1, bus2.out_rs2, bus2.out_rd}),
        192'({e.data ^ {6{e.pc}}, e.ctrl, e.rs1, e.rs2, e.rd}));
  endtask

  task automatic rand_payload();
    logic [31:0] r;
    r = $urandom;
    bus.in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.in_pc    = $urandom;
    bus.in_ctrl  = r[CW-1:0];
    bus.in_instr = $urandom;
  endtask

  // One cycle: drive after the edge, check mid-cycle, advance the model at the edge.
  task automatic step(input logic rst, input logic fl, input logic iv, input logic ordy,
                      output logic seen_rdy);
    tb_rst        = rst;
    tb_flush      = fl;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    rand_payload();
    @(negedge clock);
    check_model();
    seen_rdy = bus.in_ready;
    @(posedge clock);
    model_update();
    #1;
  endtask

  typedef struct {
    logic        rst, iv, ordy;
    logic [31:0] instr, pc;
    logic [10:0] ctrl;
    logic        e_rdy, e_vld;
    logic [31:0] e_pc;
    logic [10:0] e_ctrl;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    int          e_cnt;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic rst, logic iv, logic ordy, logic [31:0] instr, logic [31:0] pc,
                              logic [10:0] ctrl, logic e_rdy, logic e_vld, logic [31:0] e_pc,
                              logic [10:0] e_ctrl, logic [4:0] e_rs1, logic [4:0] e_rs2,
                              logic [4:0] e_rd, int e_cnt);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ordy = ordy; v.instr = instr; v.pc = pc; v.ctrl = ctrl;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_pc = e_pc; v.e_ctrl = e_ctrl;
    v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_rd = e_rd; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    logic rdy;
    int   accepted;
    int   cnt2_exp;

    // Expectations are what is visible mid-cycle, before the row's own edge.
    tbl[0]  = mk(1, 1, 1, 32'h00B50533, 32'h200,  11'h123, 0, 0, 32'h0,    11'h0,   0,  0,  0,  0);
    tbl[1]  = mk(1, 1, 1, 32'h00B50533, 32'h204,  11'h124, 0, 0, 32'h0,    11'h0,   0,  0,  0,  0);
    tbl[2]  = mk(0, 1, 1, 32'h00B50533, 32'h1000, 11'h7A1, 1, 0, 32'h0,    11'h0,   0,  0,  0,  0);
    tbl[3]  = mk(0, 1, 1, 32'h407302B3, 32'h1004, 11'h055, 1, 1, 32'h1000, 11'h7A1, 10, 11, 10, 1);
    tbl[4]  = mk(0, 1, 1, 32'h00C12403, 32'h1008, 11'h3C2, 1, 1, 32'h1004, 11'h055, 6,  7,  5,  1);
    tbl[5]  = mk(0, 1, 1, 32'hFFFFFFFF, 32'h100C, 11'h7FF, 1, 1, 32'h1008, 11'h3C2, 2,  12, 8,  1);
    tbl[6]  = mk(0, 0, 1, 32'h0,        32'h0,    11'h0,   1, 1, 32'h100C, 11'h7FF, 31, 31, 31, 1);
    tbl[7]  = mk(0, 0, 1, 32'h0,        32'h0,    11'h0,   1, 0, 32'h0,    11'h0,   0,  0,  0,  1);
    tbl[8]  = mk(0, 0, 1, 32'h0,        32'h0,    11'h0,   1, 0, 32'h0,    11'h0,   0,  0,  0,  2);
    tbl[9]  = mk(0, 0, 1, 32'h0,        32'h0,    11'h0,   1, 0, 32'h0,    11'h0,   0,  0,  0,  3);
    tbl[10] = mk(0, 0, 1, 32'h0,        32'h0,    11'h0,   1, 0, 32'h0,    11'h0,   0,  0,  0,  4);
    tbl[11] = mk(0, 0, 1, 32'h0,        32'h0,    11'h0,   1, 0, 32'h0,    11'h0,   0,  0,  0,  5);
    tbl[12] = mk(0, 0, 1, 32'h0,        32'h0,    11'h0,   1, 0, 32'h0,    11'h0,   0,  0,  0,  6);

    tb_rst = 1'b1;
    tb_flush = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    rand_payload();
    @(posedge clock);
    model_update();
    #1;

    for (int i = 0; i < 13; i++) begin
      tb_rst        = tbl[i].rst;
      tb_flush      = 1'b0;
      bus.in_valid  = tbl[i].iv;
      bus.out_ready = tbl[i].ordy;
      bus.in_instr  = tbl[i].instr;
      bus.in_pc     = tbl[i].pc;
      bus.in_ctrl   = tbl[i].ctrl;
      bus.in_data   = {6{tbl[i].pc}};
      @(negedge clock);
      cnt2_exp = (tbl[i].e_cnt > 3) ? 3 : tbl[i].e_cnt;
      chk($sformatf("vec%0d_in_ready", i),  192'(bus.in_ready),  192'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_out_valid", i), 192'(bus.out_valid), 192'(tbl[i].e_vld));
      chk($sformatf("vec%0d_out_pc", i),    192'(bus.out_pc),    192'(tbl[i].e_pc));
      chk($sformatf("vec%0d_out_data", i),  192'(bus.out_data),  192'({6{tbl[i].e_pc}}));
      chk($sformatf("vec%0d_out_ctrl", i),  192'(bus.out_ctrl),  192'(tbl[i].e_ctrl));
      chk($sformatf("vec%0d_out_regs", i),  192'({bus.out_rs1, bus.out_rs2, bus.out_rd}),
          192'({tbl[i].e_rs1, tbl[i].e_rs2, tbl[i].e_rd}));
      chk($sformatf("vec%0d_bubble_cnt", i), 192'(cnt16), 192'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_bubble_cnt_w2", i), 192'(cnt2), 192'(cnt2_exp));
      @(posedge clock);
      model_update();
      #1;
    end

    // Stall: out_ready low for 3 cycles with a steady offer; capacity bounds acceptance.
    accepted = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, rdy);
      if (rdy) accepted++;
    end
    chk("stall_accepted", 192'(accepted), 192'(CAP));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, rdy);
    chk("stall_drained", 192'(bus.out_valid), 192'(0));

    // Flush with the buffer full and a coincident offer.
    for (int i = 0; i < CAP; i++) step(0, 0, 1, 0, rdy);
    chk("flush_pre_valid", 192'(bus.out_valid), 192'(1));
    step(0, 1, 1, 0, rdy);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    chk("flush_out_valid", 192'(bus.out_valid), 192'(0));
    chk("flush_out_ctrl",  192'(bus.out_ctrl),  192'(0));
    step(0, 0, 0, 1, rdy);
    step(0, 0, 0, 1, rdy);
    chk("flush_no_delivery", 192'(bus.out_valid), 192'(0));

    // Random traffic including mid-stream reset and flush.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 60) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
           ($urandom % 3) != 0, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage_buf.md
# id_ex_stage_buf

Parametrised ID/EX pipeline stage buffer for the 5-stage RISC-V core. It sits between decode and execute and carries an opaque payload (operands, immediate, PC), a control bundle and the rs1/rs2/rd fields extracted from the instruction. Unlike a plain stage register, it uses a valid/ready handshake, so stall back-pressure is explicit and does not corrupt state. Flush inserts a zero-control bubble, and a saturating counter tracks bubble cycles for performance analysis.

## Interface
- DATA_W, 192: payload width, for example rs1 data, rs2 data and imm, 64 bits each.
- PC_W, 32: PC width.
- CTRL_W, 11: control bundle width (Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Jump, ALUcontrol[3:0]).
- CNT_W, 16: bubble counter width.

Ports:
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous flush (taken branch or jump).
- in_valid  in  1  decode holds a valid instruction.
- in_ready  out  1  the buffer accepts this cycle.
- in_data  in  DATA_W  payload.
- in_pc  in  PC_W  instruction PC.
- in_ctrl  in  CTRL_W  control bundle.
- in_instr  in  32  raw instruction.
- out_valid  out  1  the head entry is valid.
- out_ready  in  1  execute consumes the head this cycle.
- out_data  out  DATA_W  head payload.
- out_pc  out  PC_W  head PC.
- out_ctrl  out  CTRL_W  head control.
- out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], instr[24:20] and instr[11:7], captured at accept.
- bubble_cnt  out  CNT_W  saturating count of bubble cycles.

## Operation
- An input transfer (in_fire) is in_valid & in_ready. An output transfer (out_fire) is out_valid & out_ready.
- Register fields are extracted at capture time. Only rs1/rs2/rd are stored; the full instruction is not.
- When out_valid=0, every out_* field is driven to 0. This guarantees a NOP control bundle downstream.
- A flush at a clock edge has these effects:
  - All held entries are invalidated and their fields cleared to 0.
  - A coincident in_fire is discarded.
  - A coincident out_fire still counts as consumed.
  - Flush has priority over capture.
- bubble_cnt increments by 1 on every edge where out_valid=0 and out_ready=1. It holds at 2^CNT_W−1 and never wraps. Flush does not clear it; only reset does.
- Reset clears all storage, sets out_valid=0 and bubble_cnt=0, and forces in_ready=0 while reset is high. Any transfer attempted during reset is ignored.
- Reset takes priority over flush. Reset may be asserted mid-operation; all entries are lost.

## Timing
- Latency is 1 cycle: an in_fire at edge N gives out_valid=1 with that entry after edge N.
- Sustained throughput is 1 entry/cycle when out_ready=1.
- Without the skid feature:
  - A single head register is used.
  - in_ready = !reset & (!out_valid | out_ready), which is combinational from out_ready.
  - A simultaneous in_fire and out_fire replaces the head.
- With the skid feature, a 3-state FSM is used:
  - EMPTY: in_fire → ONE.
  - ONE, in_fire & out_fire: stays in ONE with the new head.
  - ONE, in_fire only: the entry goes to the skid register → TWO.
  - ONE, out_fire only: → EMPTY.
  - TWO: in_ready=0; out_fire moves skid to head → ONE.
  - flush: → EMPTY from any state.
  - in_ready = !reset & (state != TWO). This depends only on registered state.
- Entry order is strictly FIFO, and an entry is never duplicated or dropped except by flush or reset.

## Configuration
- Macro `ID_EX_SKID_EN`.
- When defined, the 2-entry skid buffer and FSM above are built, and in_ready has no combinational path from out_ready.
- When undefined, only the single-register path is built, with a combinational in_ready.
- Functional ordering, latency and flush semantics are identical in both builds. Only the in_ready timing and capacity differ.

## Test plan
- Reset: assert reset for 2 cycles with in_valid=1 → out_valid=0, all outputs 0, bubble_cnt=0, in_ready=0 during reset. After release, in_ready=1.
- Streaming: send 4 instructions with out_ready=1, including in_instr=0x00B50533 (add x10,x10,x11) → each appears 1 cycle later in order, with out_rs1=10, out_rs2=11, out_rd=10 and in_ctrl/in_data/in_pc passed through unchanged.
- Stall: hold out_ready=0 for 3 cycles while in_valid=1.
  - Skid build: 2 entries are accepted, then in_ready=0.
  - Non-skid build: 1 entry is accepted.
  - After release, entries drain in order with none lost or duplicated.
- Flush: assert flush with 2 entries held and in_valid=1 → next cycle out_valid=0 and out_ctrl=0, and the coincident input is not delivered.
- Counter: hold in_valid=0 and out_ready=1 for 5 cycles → bubble_cnt=5. With CNT_W=2, the count saturates at 3.
